// File: rtl/sprite_move_controller.sv
// Frame-synchronous mover for the overlay square: button sync, press/auto-repeat,
// wall clamping and a registered per-pixel hit flag for the colour mux.
module sprite_move_controller #(
    parameter int SCREEN_W      = 640,
    parameter int SCREEN_H      = 480,
    parameter int SIZE          = 20,
    parameter int STEP          = 5,
    parameter int INIT_X        = 0,
    parameter int INIT_Y        = 0,
    parameter int REPEAT_DELAY  = 30,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       screenEnd,
    input  logic       left,
    input  logic       right,
    input  logic       up,
    input  logic       down,
    input  logic [9:0] x,
    input  logic [8:0] y,
    output logic [9:0] squareX,
    output logic [8:0] squareY,
    output logic       inSquare,
    output logic       moving
);

    localparam int CW = $clog2(REPEAT_DELAY) + 1;

    localparam logic [CW-1:0] CNT_DELAY  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] CNT_PERIOD = CW'(REPEAT_PERIOD - 1);
    localparam logic [10:0]   MAXX       = 11'(SCREEN_W - 1 - SIZE);
    localparam logic [10:0]   MAXY       = 11'(SCREEN_H - 1 - SIZE);
    localparam logic [10:0]   STEP11     = 11'(STEP);
    localparam logic [10:0]   SIZE11     = 11'(SIZE);
    localparam logic [9:0]    SIZE10     = 10'(SIZE);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
    typedef enum logic [2:0] {D_NONE, D_L, D_R, D_U, D_D} dir_t;

    logic [3:0]    btn_meta_q, btn_sync_q;
    logic          se_q, sed_q;
    logic          frame_tick;
    dir_t          dir;
    state_t        state_q, state_d;
    dir_t          last_dir_q, last_dir_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    sq_x_q, sq_x_d;
    logic [8:0]    sq_y_q, sq_y_d;
    logic          in_sq_q, in_sq_d;
    logic          moving_q, moving_d;
    logic          do_step;
    logic [10:0]   x_ext, y_ext, x_add, y_add;
    logic [10:0]   step_x, step_y;

    // screenEnd is registered once so the tick pulse is a clean one-cycle strobe
    assign frame_tick = se_q & ~sed_q;

    always_comb begin
        if (btn_sync_q[0])      dir = D_L;
        else if (btn_sync_q[1]) dir = D_R;
        else if (btn_sync_q[2]) dir = D_U;
        else if (btn_sync_q[3]) dir = D_D;
        else                    dir = D_NONE;
    end

    always_comb begin
        x_ext  = {1'b0, sq_x_q};
        y_ext  = {2'b00, sq_y_q};
        x_add  = x_ext + STEP11;
        y_add  = y_ext + STEP11;
        step_x = x_ext;
        step_y = y_ext;
        case (dir)
            D_L:     step_x = (x_ext < STEP11) ? 11'd0 : x_ext - STEP11;
            D_R:     step_x = (x_add > MAXX) ? MAXX : x_add;
            D_U:     step_y = (y_ext < STEP11) ? 11'd0 : y_ext - STEP11;
            D_D:     step_y = (y_add > MAXY) ? MAXY : y_add;
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        last_dir_d = last_dir_q;
        cnt_d      = cnt_q;
        do_step    = 1'b0;
        if (frame_tick) begin
            unique case (state_q)
                IDLE: begin
                    if (dir != D_NONE) begin
                        do_step    = 1'b1;
                        last_dir_d = dir;
                        cnt_d      = CNT_DELAY;
                        state_d    = DELAY;
                    end
                end
                DELAY, REPEAT: begin
                    if (dir == D_NONE) begin
                        state_d = IDLE;
                    end else if (dir != last_dir_q) begin
                        do_step    = 1'b1;
                        last_dir_d = dir;
                        cnt_d      = CNT_DELAY;
                        state_d    = DELAY;
                    end else if (cnt_q == '0) begin
                        do_step = 1'b1;
                        cnt_d   = CNT_PERIOD;
                        state_d = REPEAT;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        sq_x_d   = do_step ? step_x[9:0] : sq_x_q;
        sq_y_d   = do_step ? step_y[8:0] : sq_y_q;
        moving_d = (state_d != IDLE);
        in_sq_d  = ({1'b0, x} >= x_ext) &&
                   ({1'b0, x} <= x_ext + SIZE11) &&
                   ({1'b0, y} >= {1'b0, sq_y_q}) &&
                   ({1'b0, y} <= {1'b0, sq_y_q} + SIZE10);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            se_q       <= 1'b0;
            sed_q      <= 1'b0;
            state_q    <= IDLE;
            last_dir_q <= D_NONE;
            cnt_q      <= '0;
            sq_x_q     <= 10'(INIT_X);
            sq_y_q     <= 9'(INIT_Y);
            in_sq_q    <= 1'b0;
            moving_q   <= 1'b0;
        end else begin
            btn_meta_q <= {down, up, right, left};
            btn_sync_q <= btn_meta_q;
            se_q       <= screenEnd;
            sed_q      <= se_q;
            state_q    <= state_d;
            last_dir_q <= last_dir_d;
            cnt_q      <= cnt_d;
            sq_x_q     <= sq_x_d;
            sq_y_q     <= sq_y_d;
            in_sq_q    <= in_sq_d;
            moving_q   <= moving_d;
        end
    end

    assign squareX  = sq_x_q;
    assign squareY  = sq_y_q;
    assign inSquare = in_sq_q;
    assign moving   = moving_q;

endmodule

// File: tb/tb_sprite_move_controller.sv
// Directed bench for sprite_move_controller: frames are emulated with a short
// screenEnd burst; expected positions are hand-computed step counts.
module tb_sprite_move_controller;

    localparam logic [3:0] NB = 4'b0000;
    localparam logic [3:0] BL = 4'b0001;
    localparam logic [3:0] BR = 4'b0010;
    localparam logic [3:0] BU = 4'b0100;
    localparam logic [3:0] BD = 4'b1000;

    logic       clk = 1'b0;
    logic       reset;
    logic       screenEnd;
    logic       left, right, up, down;
    logic [9:0] x;
    logic [8:0] y;
    logic [9:0] squareX;
    logic [8:0] squareY;
    logic       inSquare;
    logic       moving;

    int checks   = 0;
    int failures = 0;
    int ex;

    always #5 clk = ~clk;

    sprite_move_controller dut (
        .clk       (clk),
        .reset     (reset),
        .screenEnd (screenEnd),
        .left      (left),
        .right     (right),
        .up        (up),
        .down      (down),
        .x         (x),
        .y         (y),
        .squareX   (squareX),
        .squareY   (squareY),
        .inSquare  (inSquare),
        .moving    (moving)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_btn(input logic [3:0] m);
        left  = m[0];
        right = m[1];
        up    = m[2];
        down  = m[3];
    endtask

    // one frame: buttons settle through the synchronizer, then a screenEnd burst
    task automatic tick(input logic [3:0] m);
        set_btn(m);
        repeat (3) @(negedge clk);
        screenEnd = 1'b1;
        repeat (4) @(negedge clk);
        screenEnd = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] m, input int n);
        for (int i = 0; i < n; i++) begin
            tick(m);
            tick(NB);
        end
    endtask

    task automatic isq(input string tag, input int xv, input int yv, input logic e);
        x = 10'(xv);
        y = 9'(yv);
        @(negedge clk);
        chk(tag, {31'd0, inSquare}, {31'd0, e});
    endtask

    initial begin
        reset     = 1'b1;
        screenEnd = 1'b0;
        x         = 10'd300;
        y         = 9'd300;
        set_btn(BR);
        repeat (3) @(negedge clk);
        chk("rst_x", 32'(squareX), 0);
        chk("rst_y", 32'(squareY), 0);
        chk("rst_moving", 32'(moving), 0);
        chk("rst_insq", 32'(inSquare), 0);
        set_btn(NB);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick(NB);
        chk("idle_x", 32'(squareX), 0);
        chk("idle_y", 32'(squareY), 0);
        chk("idle_moving", 32'(moving), 0);
        chk("idle_insq", 32'(inSquare), 0);

        tick(BR);
        chk("single_x", 32'(squareX), 5);
        chk("single_moving", 32'(moving), 1);
        tick(NB);
        chk("single_rel_moving", 32'(moving), 0);
        chk("single_rel_x", 32'(squareX), 5);

        ex = 5;
        for (int i = 1; i <= 40; i++) begin
            tick(BR);
            if (i == 1 || i == 31 || i == 35 || i == 39) ex += 5;
            chk($sformatf("rep_x_t%0d", i), 32'(squareX), 32'(ex));
            chk($sformatf("rep_mv_t%0d", i), 32'(moving), 1);
        end
        chk("rep_final_x", 32'(squareX), 25);
        tick(NB);
        chk("rep_rel_moving", 32'(moving), 0);

        press(BL, 5);
        chk("to_zero_x", 32'(squareX), 0);
        for (int i = 0; i < 3; i++) begin
            tick(BL);
            chk($sformatf("clamp_left_%0d", i), 32'(squareX), 0);
        end
        chk("clamp_left_moving", 32'(moving), 1);
        tick(NB);

        press(BR, 20);
        chk("to_100_x", 32'(squareX), 100);
        tick(BL | BR);
        chk("prio_lr_x", 32'(squareX), 95);
        tick(NB);
        press(BD, 20);
        chk("to_100_y", 32'(squareY), 100);
        tick(BU | BD);
        chk("prio_ud_y", 32'(squareY), 95);
        chk("prio_ud_x", 32'(squareX), 95);
        tick(NB);

        press(BR, 1);
        press(BU, 9);
        chk("sq_pos_x", 32'(squareX), 100);
        chk("sq_pos_y", 32'(squareY), 50);
        isq("insq_120_70", 120, 70, 1'b1);
        isq("insq_121_70", 121, 70, 1'b0);
        isq("insq_99_50", 99, 50, 1'b0);
        isq("insq_100_50", 100, 50, 1'b1);
        isq("insq_100_71", 100, 71, 1'b0);
        isq("insq_100_49", 100, 49, 1'b0);
        isq("insq_110_60", 110, 60, 1'b1);
        x = 10'd300;
        y = 9'd300;

        for (int i = 0; i < 31; i++) tick(BR);
        chk("chg_pre_x", 32'(squareX), 110);
        tick(BD);
        chk("chg_y", 32'(squareY), 55);
        chk("chg_x", 32'(squareX), 110);
        chk("chg_moving", 32'(moving), 1);
        for (int i = 0; i < 29; i++) tick(BD);
        chk("chg_delay_y", 32'(squareY), 55);
        tick(BD);
        chk("chg_after_delay_y", 32'(squareY), 60);
        tick(NB);

        for (int i = 0; i < 32; i++) tick(BR);
        chk("mid_pre_x", 32'(squareX), 120);
        chk("mid_pre_moving", 32'(moving), 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_x", 32'(squareX), 0);
        chk("mid_rst_y", 32'(squareY), 0);
        chk("mid_rst_moving", 32'(moving), 0);
        @(negedge clk);
        reset = 1'b0;
        tick(BR);
        chk("mid_t1_x", 32'(squareX), 5);
        chk("mid_t1_moving", 32'(moving), 1);
        for (int i = 0; i < 29; i++) tick(BR);
        chk("mid_delay_x", 32'(squareX), 5);
        tick(BR);
        chk("mid_t31_x", 32'(squareX), 10);
        tick(NB);

        press(BR, 121);
        chk("to_615_x", 32'(squareX), 615);
        tick(BR);
        chk("clamp_right_x", 32'(squareX), 619);
        for (int i = 0; i < 30; i++) tick(BR);
        chk("clamp_right_rep_x", 32'(squareX), 619);
        chk("clamp_right_moving", 32'(moving), 1);
        tick(NB);
        press(BD, 91);
        chk("to_455_y", 32'(squareY), 455);
        tick(BD);
        chk("clamp_down_y", 32'(squareY), 459);
        tick(BD);
        chk("clamp_down_hold_y", 32'(squareY), 459);
        chk("clamp_down_x", 32'(squareX), 619);
        tick(NB);
        chk("end_moving", 32'(moving), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sprite_move_controller.md
# sprite_move_controller

Frame-synchronous position controller for the movable overlay square on the VGA display. Samples the four direction buttons once per frame, applies press/auto-repeat sequencing, clamps the square to the visible area, and outputs its top-left coordinate. Also outputs a registered per-pixel hit flag that the colour mux uses to draw the square over the image data. Sits between the board buttons and the VGA timing generator's `screenEnd`, `x` and `y` outputs.

## Interface
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- SIZE, 20, square extent; the square covers coordinates pos..pos+SIZE inclusive
- STEP, 5, pixels moved per step
- INIT_X, 0, reset X position
- INIT_Y, 0, reset Y position
- REPEAT_DELAY, 30, frames from the first step to the first auto-repeat step
- REPEAT_PERIOD, 4, frames between auto-repeat steps

Ports:
- clk  in  1  100 MHz system clock
- reset  in  1  asynchronous, active-high reset
- screenEnd  in  1  frame-boundary flag from the timing generator; high for several clk cycles per frame
- left, right, up, down  in  1 each  raw asynchronous buttons, active-high
- x  in  10  current pixel X
- y  in  9  current pixel Y
- squareX  out  10  square left edge
- squareY  out  9  square top edge
- inSquare  out  1  registered flag: current (x,y) lies inside the square
- moving  out  1  high while the FSM is not in IDLE

## Operation
- Each button passes through a 2-flop synchronizer. Synchronizer reset value is 0.
- Frame tick: register screenEnd into seD. frameTick = screenEnd & ~seD. This gives exactly one clk-cycle pulse per frame.
- Direction select, using synchronized buttons and a fixed priority: left > right > up > down. Only one direction is applied per tick. Result is dir ∈ {NONE, L, R, U, D}.
- FSM state, dir register lastDir, and counter cnt (width $clog2(REPEAT_DELAY)+1) advance only on frameTick.
  - IDLE: dir≠NONE → step(dir), lastDir=dir, cnt=REPEAT_DELAY-1, go to DELAY.
  - DELAY: if dir=NONE → IDLE. If dir≠lastDir → step(dir), reload as in IDLE, stay in DELAY. If cnt=0 → step, cnt=REPEAT_PERIOD-1, go to REPEAT. Otherwise cnt--.
  - REPEAT: if dir=NONE → IDLE. If dir≠lastDir → treat as a new press and go to DELAY. If cnt=0 → step, cnt=REPEAT_PERIOD-1. Otherwise cnt--.
- Clamp limits: MAXX = SCREEN_W-1-SIZE (619) and MAXY = SCREEN_H-1-SIZE (459). Use 11-bit intermediates.
  - Left: X<STEP ? 0 : X-STEP.
  - Right: X+STEP>MAXX ? MAXX : X+STEP.
  - Up and Down follow the same rules on Y with MAXY.
- A step that saturates still counts as a step. The FSM does not change behaviour at a wall.
- inSquare ≤ (x≥squareX)&(x≤squareX+SIZE)&(y≥squareY)&(y≤squareY+SIZE), computed with 11-bit/10-bit unsigned compares. It is registered every clk with no enable.
- moving = (state≠IDLE), decoded from state.

## Timing
- Reset, asynchronous, while asserted:
  - squareX=INIT_X, squareY=INIT_Y
  - inSquare=0, moving=0
  - state=IDLE, cnt=0, lastDir=NONE
  - synchronizers=0, seD=0
- Button to sampling: 2 clk synchronizer latency. Only the value present during the frameTick cycle matters; presses shorter than one frame that miss a tick are ignored.
- screenEnd rise to position update:
  - screenEnd first sampled high at edge N.
  - frameTick is high during cycle N..N+1.
  - squareX/squareY/state update at edge N+1.
- squareX/squareY change at most once per frame. They are stable for the whole active region.
- inSquare latency: 1 clk from x/y.
- Reset deasserted mid-DELAY or mid-REPEAT: the block restarts from IDLE at INIT position. The first step occurs on the first frameTick where a button is held.

## Test plan
- Reset: assert reset with right held → squareX=0, squareY=0, moving=0, inSquare=0 immediately (asynchronous). After release with no buttons and 5 frames, values are unchanged.
- Single press: hold right for one frameTick, then release → squareX=5 after that tick, moving=1. Next tick: moving=0, squareX stays 5.
- Auto-repeat: hold right for 40 consecutive ticks (DELAY=30, PERIOD=4) → steps on ticks 1, 31, 35, 39. squareX=20 after tick 40; moving stays 1 throughout.
- Clamp:
  - From X=0, hold left for 3 ticks → squareX stays 0.
  - Set X=617, press right → 619. Next repeat → still 619.
  - Y at 458, press down → 459.
- Priority and direction change:
  - left+right held from X=100 → X=95.
  - up+down from Y=100 → Y=95.
  - Switch from right to down in REPEAT → Y steps on that tick, FSM in DELAY with cnt=29.
- inSquare with square at (100,50):
  - x=120, y=70 → inSquare=1 one clk later.
  - x=121, y=70 → 0.
  - x=99, y=50 → 0.
  - x=100, y=50 → 1.
- Reset mid-REPEAT: reset pulse at tick 33 of a held-right run → squareX=0, moving=0. Keep holding → steps resume at tick 1 after release, then the 30-frame delay applies again.
